// File: rtl/counter_2bit.sv
// Free-running modulo-(MAX_VAL+1) up-counter with terminal-count decode and a registered wrap pulse.
// Any count above MAX_VAL returns to 0 on the next edge instead of counting on.
module counter_2bit #(
  parameter int unsigned     WIDTH   = 2,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap
);

  localparam longint unsigned MAX_LEGAL = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

  // Reject parameter sets outside the supported range at elaboration time.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_2bit: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MAX_VAL < 64'd1 || MAX_VAL > MAX_LEGAL) begin : g_bad_max
    $error("counter_2bit: MAX_VAL=%0d outside 1..%0d", MAX_VAL, MAX_LEGAL);
  end

  logic [WIDTH:0]   cnt_inc;
  logic             at_end;
  logic             past_end;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_d;

  // Next-count decision; past_end catches unreachable values so they recover to 0.
  always_comb begin
    cnt_inc  = {1'b0, cnt} + (WIDTH+1)'(1);
    at_end   = (cnt == MAX_W);
    past_end = (cnt > MAX_W) | cnt_inc[WIDTH];
    cnt_d    = cnt_inc[WIDTH-1:0];
    wrap_d   = 1'b0;
    if (at_end) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
    end else if (past_end) begin
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      wrap <= wrap_d;
    end
  end

  assign tc = at_end;

endmodule

// File: tb/tb_counter_2bit.sv
// Bench for counter_2bit: reset behaviour, wrap/tc timing, async reset mid-count,
// non-power-of-two terminal values, WIDTH=1 and recovery from an illegal count.
module tb_counter_2bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n, rst_c_n, rst_d_n;
  logic [1:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  logic [0:0] cnt_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;

  counter_2bit dut_a (.clk(clk), .rst_n(rst_a_n), .cnt(cnt_a), .tc(tc_a), .wrap(wrap_a));
  counter_2bit #(.WIDTH(2), .MAX_VAL(2)) dut_b (.clk(clk), .rst_n(rst_b_n), .cnt(cnt_b), .tc(tc_b), .wrap(wrap_b));
  counter_2bit #(.WIDTH(3), .MAX_VAL(4)) dut_c (.clk(clk), .rst_n(rst_c_n), .cnt(cnt_c), .tc(tc_c), .wrap(wrap_c));
  counter_2bit #(.WIDTH(1)) dut_d (.clk(clk), .rst_n(rst_d_n), .cnt(cnt_d), .tc(tc_d), .wrap(wrap_d));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] cnt;
    logic        tc;
    logic        wrap;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       rst_n;
    logic [1:0] cnt;
    logic       tc;
    logic       wrap;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input int which, output logic [31:0] c, output logic t, output logic w);
    case (which)
      0:       begin c = 32'(cnt_a); t = tc_a; w = wrap_a; end
      1:       begin c = 32'(cnt_b); t = tc_b; w = wrap_b; end
      2:       begin c = 32'(cnt_c); t = tc_c; w = wrap_c; end
      default: begin c = 32'(cnt_d); t = tc_d; w = wrap_d; end
    endcase
  endtask

  task automatic push(input string name, input logic [31:0] c, input logic t, input logic w);
    exp_t e;
    e.name = name;
    e.cnt  = c;
    e.tc   = t;
    e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int which);
    exp_t        e;
    logic [31:0] c;
    logic        t, w;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
      return;
    end
    e = sb.pop_front();
    sample(which, c, t, w);
    check({e.name, "_cnt"},  c,        e.cnt);
    check({e.name, "_tc"},   32'(t),   32'(e.tc));
    check({e.name, "_wrap"}, 32'(w),   32'(e.wrap));
  endtask

  // Reference model: expected state is pushed at each rising edge, compared at the falling edge.
  task automatic run_model(input int which, input int unsigned maxv, input int cycles);
    int unsigned m;
    logic        ew;
    m = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      ew = (m == maxv);
      m  = ew ? 0 : m + 1;
      push($sformatf("dut%0d_cyc%0d", which, i), 32'(m), (m == maxv), ew);
      @(negedge clk);
      pop_check(which);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic seen;

    vecs[0] = '{1'b1, 2'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd3, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'd0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 2'd1, 1'b0, 1'b0};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    rst_c_n = 1'b0;
    rst_d_n = 1'b0;

    // Reset held across the 5 ns edge.
    #1;
    check("rst_cnt",  32'(cnt_a),  32'd0);
    check("rst_tc",   32'(tc_a),   32'd0);
    check("rst_wrap", 32'(wrap_a), 32'd0);
    check("rst_d_tc", 32'(tc_d),   32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_cnt",  32'(cnt_a),  32'd0);
    check("rst_edge_wrap", 32'(wrap_a), 32'd0);

    // Release at 12 ns; sample after edges 15..55 at the falling edges.
    #6;
    for (int i = 0; i < 5; i++) begin
      rst_a_n = vecs[i].rst_n;
      @(negedge clk);
      push($sformatf("vec%0d", i), 32'(vecs[i].cnt), vecs[i].tc, vecs[i].wrap);
      pop_check(0);
    end

    // Async reset while cnt==3.
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_async_cnt", 32'(cnt_a), 32'd3);
    check("pre_async_tc",  32'(tc_a),  32'd1);
    rst_a_n = 1'b0;
    #1;
    check("async_cnt",  32'(cnt_a),  32'd0);
    check("async_tc",   32'(tc_a),   32'd0);
    check("async_wrap", 32'(wrap_a), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_cnt", i), 32'(cnt_a), 32'd0);
    end
    @(negedge clk);
    rst_a_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_cnt", 32'(cnt_a), 32'd1);

    // Cancel an in-flight wrap pulse.
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (wrap_a === 1'b1) seen = 1'b1;
    end
    check("wrap_seen", 32'(seen), 32'd1);
    rst_a_n = 1'b0;
    #1;
    check("cancel_wrap", 32'(wrap_a), 32'd0);
    check("cancel_cnt",  32'(cnt_a),  32'd0);
    @(posedge clk);
    #1;
    check("cancel_hold_wrap", 32'(wrap_a), 32'd0);

    // MAX_VAL=2 in 2 bits: 0,1,2,0,... with wrap every third cycle.
    @(negedge clk);
    rst_b_n = 1'b1;
    run_model(1, 2, 12);

    // Illegal count above MAX_VAL recovers to 0 on the next edge.
    @(negedge clk);
    rst_c_n = 1'b1;
    run_model(2, 4, 4);
    force dut_c.cnt = 3'd6;
    #1;
    release dut_c.cnt;
    @(posedge clk);
    #1;
    check("recover_cnt", 32'(cnt_c), 32'd0);
    @(posedge clk);
    #1;
    check("recover_next_cnt", 32'(cnt_c), 32'd1);

    // WIDTH=1, MAX_VAL=1: toggles, wrap every other cycle.
    @(negedge clk);
    rst_d_n = 1'b1;
    run_model(3, 1, 6);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
